// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter for instruction fetch and load/store traffic.
// Grants one access at a time, alternates under contention, and aborts stalled accesses.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_fetch_req,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_data_req,
    input  logic                  i_data_we,
    input  logic [ADDR_WIDTH-1:0] i_result,
    input  logic                  i_mem_done,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic                  o_addr_sel,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_fetch_ack,
    output logic                  o_data_ack,
    output logic                  o_timeout,
    output logic                  o_busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA} state_e;
    typedef enum logic {G_FETCH, G_DATA} grant_e;

    state_e                state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic                  addr_sel_q, addr_sel_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  fetch_ack_q, fetch_ack_d;
    logic                  data_ack_q, data_ack_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q, busy_d;

    logic fetch_elig, data_elig, grant_data;

    // A requester acked this cycle is masked so the other side gets the port next.
    assign fetch_elig = i_fetch_req & ~fetch_ack_q;
    assign data_elig  = i_data_req & ~data_ack_q;
    assign grant_data = data_elig & (~fetch_elig | (last_grant_q == G_FETCH));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        addr_sel_d   = addr_sel_q;
        mem_addr_d   = mem_addr_q;
        busy_d       = busy_q;
        fetch_ack_d  = 1'b0;
        data_ack_d   = 1'b0;
        timeout_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (fetch_elig | data_elig) begin
                    state_d      = grant_data ? S_DATA : S_FETCH;
                    last_grant_d = grant_data ? G_DATA : G_FETCH;
                    mem_req_d    = 1'b1;
                    busy_d       = 1'b1;
                    addr_sel_d   = grant_data;
                    mem_addr_d   = grant_data ? i_result : i_pc;
                    mem_we_d     = grant_data & i_data_we;
                    cnt_d        = '0;
                end
            end
            S_FETCH, S_DATA: begin
                if (i_mem_done) begin
                    state_d     = S_IDLE;
                    mem_req_d   = 1'b0;
                    busy_d      = 1'b0;
                    fetch_ack_d = (state_q == S_FETCH);
                    data_ack_d  = (state_q == S_DATA);
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= G_DATA;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            addr_sel_q   <= 1'b0;
            mem_addr_q   <= '0;
            fetch_ack_q  <= 1'b0;
            data_ack_q   <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            addr_sel_q   <= addr_sel_d;
            mem_addr_q   <= mem_addr_d;
            fetch_ack_q  <= fetch_ack_d;
            data_ack_q   <= data_ack_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_addr_sel  = addr_sel_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_fetch_ack = fetch_ack_q;
    assign o_data_ack  = data_ack_q;
    assign o_timeout   = timeout_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
// The model tracks one outstanding access by its grant time rather than a wait counter.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_fetch_req = 1'b0;
    logic [AW-1:0] i_pc = '0;
    logic          i_data_req = 1'b0;
    logic          i_data_we = 1'b0;
    logic [AW-1:0] i_result = '0;
    logic          i_mem_done = 1'b0;
    logic          o_mem_req, o_mem_we, o_addr_sel;
    logic [AW-1:0] o_mem_addr;
    logic          o_fetch_ack, o_data_ack, o_timeout, o_busy;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_fetch_req(i_fetch_req), .i_pc(i_pc),
        .i_data_req(i_data_req), .i_data_we(i_data_we), .i_result(i_result),
        .i_mem_done(i_mem_done),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_addr_sel(o_addr_sel),
        .o_mem_addr(o_mem_addr), .o_fetch_ack(o_fetch_ack), .o_data_ack(o_data_ack),
        .o_timeout(o_timeout), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic          s_rst, s_f, s_d, s_we, s_done;
    logic [AW-1:0] s_pc, s_res;
    always @(posedge clk) begin
        s_rst  <= rst;
        s_f    <= i_fetch_req;
        s_d    <= i_data_req;
        s_we   <= i_data_we;
        s_done <= i_mem_done;
        s_pc   <= i_pc;
        s_res  <= i_result;
    end

    // Model: one access record {kind, addr, we, grant edge}; outputs derived from it.
    int unsigned   edge_no = 0;
    int unsigned   m_grant_edge = 0;
    bit            m_valid = 0;
    bit            m_active = 0, m_is_data = 0, m_we = 0, m_last_data = 1;
    bit            m_fack = 0, m_dack = 0, m_to = 0;
    logic [AW-1:0] m_addr = '0;

    always @(negedge clk) begin
        bit want_f, want_d, take_d;
        edge_no++;
        if (s_rst === 1'b1) begin
            m_valid = 1; m_active = 0; m_is_data = 0; m_we = 0; m_addr = '0;
            m_last_data = 1; m_fack = 0; m_dack = 0; m_to = 0;
        end else if (m_valid) begin
            want_f = s_f && !m_fack;
            want_d = s_d && !m_dack;
            m_fack = 0; m_dack = 0; m_to = 0;
            if (m_active) begin
                if (s_done) begin
                    m_active = 0;
                    if (m_is_data) m_dack = 1; else m_fack = 1;
                end else if (edge_no - m_grant_edge > TO) begin
                    m_active = 0;
                    m_to = 1;
                end
            end else if (want_f || want_d) begin
                take_d = want_d && (!want_f || !m_last_data);
                m_active = 1;
                m_is_data = take_d;
                m_last_data = take_d;
                m_addr = take_d ? s_res : s_pc;
                m_we = take_d && s_we;
                m_grant_edge = edge_no;
            end
        end
        if (m_valid) begin
            chk("mdl_mem_req", o_mem_req, m_active);
            chk("mdl_busy", o_busy, m_active);
            chk("mdl_mem_we", o_mem_we, m_we);
            chk("mdl_addr_sel", o_addr_sel, m_is_data);
            chk("mdl_mem_addr", o_mem_addr, m_addr);
            chk("mdl_fetch_ack", o_fetch_ack, m_fack);
            chk("mdl_data_ack", o_data_ack, m_dack);
            chk("mdl_timeout", o_timeout, m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_fetch_req = 1'b0; i_data_req = 1'b0; i_mem_done = 1'b0; i_data_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n, acks, pct;
        // Single fetch, done three cycles after request
        do_reset();
        chk("rst_mem_req", o_mem_req, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_busy", o_busy, 0);
        i_fetch_req = 1'b1; i_pc = 64'h1000;
        tick();
        chk("f_mem_req", o_mem_req, 1);
        chk("f_addr_sel", o_addr_sel, 0);
        chk("f_mem_addr", o_mem_addr, 64'h1000);
        chk("f_mem_we", o_mem_we, 0);
        i_fetch_req = 1'b0;
        tick();
        tick();
        i_mem_done = 1'b1;
        tick();
        i_mem_done = 1'b0;
        chk("f_ack", o_fetch_ack, 1);
        chk("f_req_low", o_mem_req, 0);
        tick();
        chk("f_ack_once", o_fetch_ack, 0);

        // Contention: strict alternation, other side granted out of each ack cycle
        do_reset();
        i_fetch_req = 1'b1; i_data_req = 1'b1; i_pc = 64'h100; i_result = 64'h200; i_data_we = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("alt_req", o_mem_req, 1);
            chk("alt_sel", o_addr_sel, i % 2);
            tick();
            i_mem_done = 1'b1;
            tick();
            i_mem_done = 1'b0;
            chk("alt_ack", (i % 2) ? o_data_ack : o_fetch_ack, 1);
            tick();
        end
        i_fetch_req = 1'b0; i_data_req = 1'b0;
        i_mem_done = 1'b1;
        tick();
        i_mem_done = 1'b0;

        // Store with inputs disturbed mid-access
        do_reset();
        i_data_req = 1'b1; i_result = 64'h2008; i_data_we = 1'b1;
        tick();
        i_result = 64'hFFFF; i_data_req = 1'b0; i_data_we = 1'b0;
        tick();
        tick();
        chk("st_addr", o_mem_addr, 64'h2008);
        chk("st_we", o_mem_we, 1);
        chk("st_sel", o_addr_sel, 1);
        i_mem_done = 1'b1;
        tick();
        i_mem_done = 1'b0;
        chk("st_ack", o_data_ack, 1);
        chk("st_hold_addr", o_mem_addr, 64'h2008);

        // Timeout with no done
        do_reset();
        i_fetch_req = 1'b1; i_pc = 64'h3000;
        tick();
        i_fetch_req = 1'b0;
        n = 0; acks = 0;
        while (n < 40 && o_timeout !== 1'b1) begin
            tick();
            n++;
            if (o_fetch_ack === 1'b1 || o_data_ack === 1'b1) acks++;
        end
        chk("to_delay", n, 17);
        chk("to_no_ack", acks, 0);
        chk("to_idle", o_busy, 0);
        tick();
        chk("to_pulse", o_timeout, 0);

        // Done on the timeout cycle wins
        do_reset();
        i_fetch_req = 1'b1;
        tick();
        i_fetch_req = 1'b0;
        repeat (16) tick();
        chk("tod_req", o_mem_req, 1);
        i_mem_done = 1'b1;
        tick();
        i_mem_done = 1'b0;
        chk("tod_ack", o_fetch_ack, 1);
        chk("tod_no_to", o_timeout, 0);

        // Reset mid data access
        do_reset();
        i_data_req = 1'b1; i_result = 64'h4000; i_data_we = 1'b1;
        tick();
        tick();
        rst = 1'b1; i_data_req = 1'b0;
        tick();
        chk("mr_req", o_mem_req, 0);
        chk("mr_addr", o_mem_addr, 0);
        chk("mr_we", o_mem_we, 0);
        chk("mr_ack", o_data_ack, 0);
        chk("mr_to", o_timeout, 0);
        rst = 1'b0; i_fetch_req = 1'b1; i_data_req = 1'b1;
        tick();
        chk("mr_fetch_first", o_addr_sel, 0);
        chk("mr_granted", o_mem_req, 1);

        // Random traffic, done probability varied per segment
        pct = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) pct = (c / 400) % 4 == 1 ? 0 : ((c / 400) % 4) * 20 + 5;
            rst         = ($urandom_range(0, 199) == 0);
            i_fetch_req = ($urandom_range(0, 99) < 60);
            i_data_req  = ($urandom_range(0, 99) < 55);
            i_data_we   = $urandom_range(0, 1);
            i_pc        = {$urandom, $urandom};
            i_result    = {$urandom, $urandom};
            i_mem_done  = ($urandom_range(0, 99) < pct);
            tick();
        end
        rst = 1'b0; i_fetch_req = 1'b0; i_data_req = 1'b0; i_mem_done = 1'b0;
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 64, width of fetch, data and memory addresses.
REQ-002 Parameter TIMEOUT_CYCLES, 16, max cycles an access waits for i_mem_done before abort; counter width $clog2(TIMEOUT_CYCLES+1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_fetch_req  input  1  fetch requester wants the memory port.
REQ-006 i_pc  input  ADDR_WIDTH  fetch address (PCNext).
REQ-007 i_data_req  input  1  load/store requester wants the memory port.
REQ-008 i_data_we  input  1  data access is a store (1) or load (0).
REQ-009 i_result  input  ADDR_WIDTH  data address (calculated result).
REQ-010 i_mem_done  input  1  memory completes the current access this cycle.
REQ-011 o_mem_req  output  1  access in progress; held high until done or timeout.
REQ-012 o_mem_we  output  1  registered write enable of granted access; always 0 for fetch.
REQ-013 o_addr_sel  output  1  address-mux control: 0 selects PC, 1 selects result.
REQ-014 o_mem_addr  output  ADDR_WIDTH  registered address of granted access.
REQ-015 o_fetch_ack, o_data_ack  output  1 each  one-cycle completion pulses.
REQ-016 o_timeout  output  1  one-cycle pulse on aborted access.
REQ-017 o_busy  output  1  high in FETCH or DATA state.

Function
REQ-018 FSM SHALL have states IDLE, FETCH, DATA, plus a 1-bit last_grant register (FETCH/DATA).
REQ-019 IDLE, no eligible request: stay IDLE, o_mem_req=0.
REQ-020 IDLE, one eligible request: grant it at the edge; next cycle state=FETCH or DATA.
REQ-021 IDLE, both eligible: grant the requester not equal to last_grant (strict alternation).
REQ-022 On grant SHALL capture i_pc/0 (fetch) or i_result/i_data_we (data) into o_mem_addr/o_mem_we, set o_addr_sel (0 fetch, 1 data), set last_grant, clear wait counter.
REQ-023 Latency: request sampled at edge N -> o_mem_req=1 from cycle N+1.
REQ-024 Input changes to i_pc, i_result, i_data_we, or request deassertion during FETCH/DATA SHALL be ignored; access completes with captured values.
REQ-025 FETCH/DATA: counter increments each cycle without i_mem_done.
REQ-026 i_mem_done=1 sampled in FETCH/DATA: next cycle state=IDLE, o_mem_req=0, matching ack=1 for exactly that cycle.
REQ-027 In the ack cycle the acked requester SHALL be masked (ineligible); the other requester may be granted in that cycle.
REQ-028 Counter reaching TIMEOUT_CYCLES with i_mem_done=0: next cycle state=IDLE, o_timeout=1 one cycle, no ack, no masking.
REQ-029 i_mem_done and timeout in same cycle: done wins, ack issued, no o_timeout.
REQ-030 i_mem_done while IDLE SHALL be ignored.
REQ-031 o_addr_sel, o_mem_addr, o_mem_we SHALL hold last granted values while IDLE.

Reset
REQ-032 rst=1 at an edge SHALL force state=IDLE, last_grant=DATA, counter=0, and all outputs 0, including mid-access (access aborted, no ack, no timeout).
REQ-033 First cycle after rst deasserts SHALL be able to grant; with both requesting, fetch wins.

Verification
REQ-034 Reset, then i_fetch_req=1, i_pc=0x1000 at cycle 0 -> cycle 1 o_mem_req=1, o_addr_sel=0, o_mem_addr=0x1000, o_mem_we=0; i_mem_done at cycle 3 -> o_fetch_ack=1 cycle 4 only.
REQ-035 Both requests held continuously, i_mem_done 2 cycles after each grant -> grants alternate fetch, data, fetch, data; the other requester is granted in each ack cycle.
REQ-036 Data store i_result=0x2008, i_data_we=1; i_result changed to 0xFFFF and i_data_req dropped mid-access -> o_mem_addr stays 0x2008, o_mem_we=1, o_data_ack on completion.
REQ-037 TIMEOUT_CYCLES=16, i_mem_done never asserted -> o_timeout pulse exactly 17 cycles after o_mem_req rises, no ack, FSM IDLE; variant with i_mem_done on the timeout cycle -> ack, no o_timeout.
REQ-038 rst asserted 2 cycles into a data access -> next cycle all outputs 0, no ack; following contention grants fetch first.
